trap_ctrl: RTL and testbench

Sequencer for synchronous exceptions and `mret` in the nexus-v core. It sits between the execute stage and the CSR unit and drives that unit's trap inputs (`trap_enter`, `trap_pc`, `trap_cause`, `mret_exec`). It consumes the CSR unit's `mtvec`/`mepc` outputs to issue a PC redirect. It also stalls and flushes the pipeline for the duration of each trap entry or return.

---
 rtl/trap_ctrl_pkg.sv | 24 ++
 rtl/trap_prio_enc.sv | 25 ++
 rtl/trap_ctrl.sv | 126 ++++++++++++
 tb/tb_trap_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared trap sequencer definitions: mcause codes, FSM states, encoder payload.
package trap_ctrl_pkg;

  localparam int unsigned CAUSE_W = 4;

  localparam logic [CAUSE_W-1:0] CAUSE_IADDR_MISALIGN = 4'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL        = 4'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_BREAKPOINT     = 4'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_ECALL_M        = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ENTER    = 2'd1,
    ST_RETURN   = 2'd2,
    ST_REDIRECT = 2'd3
  } trap_state_e;

  // Priority-encoder result: any trap flag set, plus the winning cause code.
  typedef struct packed {
    logic               any_trap;
    logic [CAUSE_W-1:0] cause;
  } trap_evt_t;

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational priority encoder for synchronous exception flags.
// Ports:
//   misalign, illegal, ebreak, ecall : decoded exception flags
//   evt                              : {any_trap, cause}, misalign highest
module trap_prio_enc
  import trap_ctrl_pkg::*;
(
  input  logic      misalign,
  input  logic      illegal,
  input  logic      ebreak,
  input  logic      ecall,
  output trap_evt_t evt
);

  // First set flag in architectural priority order selects the cause.
  always_comb begin
    evt          = '0;
    evt.any_trap = misalign | illegal | ebreak | ecall;
    if (misalign)     evt.cause = CAUSE_IADDR_MISALIGN;
    else if (illegal) evt.cause = CAUSE_ILLEGAL;
    else if (ebreak)  evt.cause = CAUSE_BREAKPOINT;
    else if (ecall)   evt.cause = CAUSE_ECALL_M;
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap entry / MRET sequencer between execute stage and CSR unit.
// Samples exceptions or MRET in IDLE, pulses trap_enter or mret_exec to the
// CSR unit, then issues a PC redirect (mtvec or mepc, word aligned) and holds
// it until fetch accepts. The pipeline is stalled whenever not IDLE.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   ex_*                       : execute-stage instruction valid/PC/flags
//   mtvec_in, mepc_in          : CSR unit vector base and saved PC
//   redirect_ready             : fetch accepts redirect
//   trap_enter, trap_pc,
//   trap_cause, mret_exec      : CSR unit trap inputs
//   pipe_stall, pipe_flush     : pipeline control
//   redirect_valid/redirect_pc : new fetch PC
//   busy                       : sequencer not IDLE
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_misalign,
  input  logic            ex_illegal,
  input  logic            ex_ebreak,
  input  logic            ex_ecall,
  input  logic            ex_mret,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  input  logic            redirect_ready,
  output logic            trap_enter,
  output logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] trap_cause,
  output logic            mret_exec,
  output logic            pipe_stall,
  output logic            pipe_flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  trap_state_e        state;
  trap_evt_t          evt;
  logic [XLEN-1:0]    pc_q;
  logic [CAUSE_W-1:0] cause_q;
  logic [XLEN-1:0]    tgt_q;

  trap_prio_enc u_prio_enc (
    .misalign (ex_misalign),
    .illegal  (ex_illegal),
    .ebreak   (ex_ebreak),
    .ecall    (ex_ecall),
    .evt      (evt)
  );

  // Capture registers are presented directly; trap_enter qualifies them.
  assign trap_pc     = pc_q;
  assign trap_cause  = XLEN'(cause_q);
  assign redirect_pc = tgt_q;

  // Sequencer: state, capture registers and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      pc_q           <= '0;
      cause_q        <= '0;
      tgt_q          <= '0;
      trap_enter     <= 1'b0;
      mret_exec      <= 1'b0;
      pipe_stall     <= 1'b0;
      pipe_flush     <= 1'b0;
      redirect_valid <= 1'b0;
      busy           <= 1'b0;
    end else begin
      trap_enter <= 1'b0;
      mret_exec  <= 1'b0;
      pipe_flush <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Any trap cause outranks a coincident MRET.
          if (ex_valid && evt.any_trap) begin
            pc_q       <= ex_pc;
            cause_q    <= evt.cause;
            trap_enter <= 1'b1;
            pipe_flush <= 1'b1;
            pipe_stall <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_ENTER;
          end else if (ex_valid && ex_mret) begin
            mret_exec  <= 1'b1;
            pipe_flush <= 1'b1;
            pipe_stall <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_RETURN;
          end
        end
        ST_ENTER: begin
          tgt_q          <= {mtvec_in[XLEN-1:2], 2'b00};
          redirect_valid <= 1'b1;
          state          <= ST_REDIRECT;
        end
        ST_RETURN: begin
          tgt_q          <= {mepc_in[XLEN-1:2], 2'b00};
          redirect_valid <= 1'b1;
          state          <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            pipe_stall     <= 1'b0;
            busy           <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        default: begin
          redirect_valid <= 1'b0;
          pipe_stall     <= 1'b0;
          busy           <= 1'b0;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: driver pushes expected CSR pulses and
// redirect handshakes; a negedge monitor pops and compares them.
module tb_trap_ctrl;

  localparam int unsigned XLEN = 32;
  localparam int K_TRAP  = 0;
  localparam int K_MRET  = 1;
  localparam int K_REDIR = 2;

  typedef struct {
    int          kind;
    logic [31:0] pc;
    logic [31:0] cause;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ex_valid, ex_misalign, ex_illegal, ex_ebreak, ex_ecall, ex_mret;
  logic [XLEN-1:0] ex_pc, mtvec_in, mepc_in;
  logic            redirect_ready;
  logic            trap_enter, mret_exec, pipe_stall, pipe_flush, redirect_valid, busy;
  logic [XLEN-1:0] trap_pc, trap_cause, redirect_pc;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_misalign    (ex_misalign),
    .ex_illegal     (ex_illegal),
    .ex_ebreak      (ex_ebreak),
    .ex_ecall       (ex_ecall),
    .ex_mret        (ex_mret),
    .mtvec_in       (mtvec_in),
    .mepc_in        (mepc_in),
    .redirect_ready (redirect_ready),
    .trap_enter     (trap_enter),
    .trap_pc        (trap_pc),
    .trap_cause     (trap_cause),
    .mret_exec      (mret_exec),
    .pipe_stall     (pipe_stall),
    .pipe_flush     (pipe_flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] pc, input logic [31:0] cause);
    exp_t e;
    e.kind  = kind;
    e.pc    = pc;
    e.cause = cause;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid    = 1'b0;
    ex_misalign = 1'b0;
    ex_illegal  = 1'b0;
    ex_ebreak   = 1'b0;
    ex_ecall    = 1'b0;
    ex_mret     = 1'b0;
  endtask

  // Monitor: every CSR pulse and every redirect handshake consumes one entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (trap_enter && mret_exec) chk("enter_and_mret", 32'd1, 32'd0);
      if (trap_enter || mret_exec) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, trap_enter, mret_exec}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", trap_enter ? K_TRAP : K_MRET, 32'(e.kind));
          chk("pulse_flush", 32'(pipe_flush), 32'd1);
          if (e.kind == K_TRAP) begin
            chk("trap_pc", trap_pc, e.pc);
            chk("trap_cause", trap_cause, e.cause);
          end
        end
      end
      if (redirect_valid && redirect_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_redirect", redirect_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("redir_kind", K_REDIR, 32'(e.kind));
          chk("redirect_pc", redirect_pc, e.pc);
        end
      end
    end
  end

  initial begin
    clear_ex();
    ex_pc          = '0;
    mtvec_in       = '0;
    mepc_in        = '0;
    redirect_ready = 1'b1;
    rst_n          = 1'b0;
    step();
    step();
    chk("rst_ctl", 32'({trap_enter, mret_exec, pipe_stall, pipe_flush, redirect_valid, busy}), 32'd0);
    chk("rst_pcs", trap_pc | trap_cause | redirect_pc, 32'd0);
    rst_n = 1'b1;
    step();

    // ECALL: exact T+1 / T+2 / T+3 timing.
    ex_valid = 1'b1; ex_ecall = 1'b1; ex_pc = 32'h40; mtvec_in = 32'h100;
    push(K_TRAP, 32'h40, 32'd11);
    push(K_REDIR, 32'h100, 32'd0);
    step();
    clear_ex();
    chk("ecall_t1_enter", 32'(trap_enter), 32'd1);
    chk("ecall_t1_flush", 32'(pipe_flush), 32'd1);
    chk("ecall_t1_stall", 32'(pipe_stall), 32'd1);
    step();
    chk("ecall_t2_valid", 32'(redirect_valid), 32'd1);
    chk("ecall_t2_pc", redirect_pc, 32'h100);
    step();
    chk("ecall_t3_busy", 32'(busy), 32'd0);

    // Several traps with MRET: illegal wins, mret_exec must never pulse.
    ex_valid = 1'b1; ex_illegal = 1'b1; ex_ebreak = 1'b1; ex_ecall = 1'b1; ex_mret = 1'b1;
    ex_pc = 32'h200; mtvec_in = 32'h300;
    push(K_TRAP, 32'h200, 32'd2);
    push(K_REDIR, 32'h300, 32'd0);
    step();
    clear_ex();
    chk("multi_no_mret", 32'(mret_exec), 32'd0);
    step();
    step();

    // Misalign outranks illegal; unaligned mtvec is word aligned.
    ex_valid = 1'b1; ex_misalign = 1'b1; ex_illegal = 1'b1;
    ex_pc = 32'h1002; mtvec_in = 32'h103;
    push(K_TRAP, 32'h1002, 32'd0);
    push(K_REDIR, 32'h100, 32'd0);
    step();
    clear_ex();
    step();
    step();

    // MRET to mepc 0x46 -> redirect 0x44.
    ex_valid = 1'b1; ex_mret = 1'b1; mepc_in = 32'h46;
    push(K_MRET, 32'h0, 32'h0);
    push(K_REDIR, 32'h44, 32'd0);
    step();
    clear_ex();
    chk("mret_t1_exec", 32'(mret_exec), 32'd1);
    chk("mret_t1_enter", 32'(trap_enter), 32'd0);
    step();
    chk("mret_t2_pc", redirect_pc, 32'h44);
    step();

    // Redirect stalled by fetch; a re-presented ECALL must not re-trap.
    ex_valid = 1'b1; ex_ecall = 1'b1; ex_pc = 32'h500; mtvec_in = 32'h600;
    redirect_ready = 1'b0;
    push(K_TRAP, 32'h500, 32'd11);
    push(K_REDIR, 32'h600, 32'd0);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", 32'(redirect_valid), 32'd1);
      chk("hold_pc", redirect_pc, 32'h600);
      if (i == 3) begin
        redirect_ready = 1'b1;
        clear_ex();
      end
      step();
    end
    chk("hold_hs_busy", 32'(busy), 32'd0);

    // Reset asserted in REDIRECT: outputs clear immediately, no redirect later.
    ex_valid = 1'b1; ex_ecall = 1'b1; ex_pc = 32'h700; mtvec_in = 32'h800;
    redirect_ready = 1'b0;
    push(K_TRAP, 32'h700, 32'd11);
    step();
    clear_ex();
    step();
    chk("pre_rst_valid", 32'(redirect_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", 32'({trap_enter, mret_exec, pipe_stall, pipe_flush, redirect_valid, busy}), 32'd0);
    chk("mid_rst_pcs", trap_pc | trap_cause | redirect_pc, 32'd0);
    step();
    rst_n = 1'b1;
    redirect_ready = 1'b1;
    step();
    chk("post_rst_busy", 32'(busy), 32'd0);

    // EBREAK after reset.
    ex_valid = 1'b1; ex_ebreak = 1'b1; ex_pc = 32'h80; mtvec_in = 32'h900;
    push(K_TRAP, 32'h80, 32'd3);
    push(K_REDIR, 32'h900, 32'd0);
    step();
    clear_ex();
    step();
    step();

    // ex_valid low: flags are ignored.
    ex_ecall = 1'b1; ex_mret = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("invalid_busy", 32'(busy), 32'd0);
    end
    clear_ex();
    step();
    step();

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
